// File: rtl/adc_spi_capture_if.sv
// rtl/adc_spi_capture_if.sv - signal bundle between adc_spi_capture and its divider, ADC and acquisition datapath
// Ports (slave = capture controller view):
//   start_i      in   frame request
//   sclk_div_i   in   divided clock from the paired clock_div
//   miso_i       in   ADC serial data
//   div_en_o     out  divider enable
//   div_clear_o  out  divider clear
//   busy_o       out  controller not idle
//   cs_n_o       out  ADC chip select, active-low
//   sclk_o       out  ADC serial clock
//   data_o       out  last captured word
//   valid_o      out  one-cycle strobe when data_o updates
interface adc_spi_capture_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  start_i;
    logic                  sclk_div_i;
    logic                  miso_i;
    logic                  div_en_o;
    logic                  div_clear_o;
    logic                  busy_o;
    logic                  cs_n_o;
    logic                  sclk_o;
    logic [DATA_WIDTH-1:0] data_o;
    logic                  valid_o;

    modport slave (
        input  start_i, sclk_div_i, miso_i,
        output div_en_o, div_clear_o, busy_o, cs_n_o, sclk_o, data_o, valid_o
    );

    modport master (
        output start_i, sclk_div_i, miso_i,
        input  div_en_o, div_clear_o, busy_o, cs_n_o, sclk_o, data_o, valid_o
    );
endinterface

// File: rtl/adc_spi_capture.sv
// rtl/adc_spi_capture.sv - framed MSB-first SPI mode-0 read of a serial ADC, clocked from a gated divider
// Ports:
//   clock_in_i  in   system clock, rising edge
//   reset_i     in   asynchronous active-high reset
//   bus         adc_spi_capture_if.slave: start/busy, divider control,
//               SPI pins (cs_n_o, sclk_o, miso_i) and captured word (data_o, valid_o)
module adc_spi_capture #(
    parameter int DATA_WIDTH     = 16,
    parameter int CS_HIGH_CYCLES = 4
) (
    input  logic               clock_in_i,
    input  logic               reset_i,
    adc_spi_capture_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        RECOVER
    } state_t;

    localparam int BIT_CNT_W    = $clog2(DATA_WIDTH + 1);
    localparam int RECOVER_LEN  = (CS_HIGH_CYCLES < 1) ? 1 : CS_HIGH_CYCLES;
    localparam int REC_CNT_W    = $clog2(RECOVER_LEN + 1);

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);
    localparam logic [REC_CNT_W-1:0] REC_LOAD = REC_CNT_W'(RECOVER_LEN);
    localparam logic [REC_CNT_W-1:0] REC_ONE  = REC_CNT_W'(1);

    state_t                  state;
    logic                    sclk_q;
    logic [BIT_CNT_W-1:0]    bit_cnt;
    logic [REC_CNT_W-1:0]    rec_cnt;
    logic [DATA_WIDTH-1:0]   shift_reg;
    logic [DATA_WIDTH-1:0]   shift_next;

    logic                    cs_n_r;
    logic                    sclk_r;
    logic                    div_en_r;
    logic                    div_clear_r;
    logic                    busy_r;
    logic                    valid_r;
    logic [DATA_WIDTH-1:0]   data_r;

    logic                    sclk_rise;
    logic                    sclk_fall;

    // sclk_div_i is already a register in this clock domain, so the edge
    // detector compares it straight against its one-cycle-delayed copy.
    assign sclk_rise = bus.sclk_div_i & ~sclk_q;
    assign sclk_fall = ~bus.sclk_div_i & sclk_q;

    // New bit enters at the LSB; the truncating cast keeps this legal for
    // a one-bit shift register as well.
    assign shift_next = DATA_WIDTH'({shift_reg, bus.miso_i});

    always_ff @(posedge clock_in_i or posedge reset_i) begin
        if (reset_i) begin
            state       <= IDLE;
            sclk_q      <= 1'b0;
            bit_cnt     <= '0;
            rec_cnt     <= '0;
            shift_reg   <= '0;
            cs_n_r      <= 1'b1;
            sclk_r      <= 1'b0;
            div_en_r    <= 1'b0;
            div_clear_r <= 1'b1;
            busy_r      <= 1'b0;
            valid_r     <= 1'b0;
            data_r      <= '0;
        end else begin
            sclk_q  <= bus.sclk_div_i;
            valid_r <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        cs_n_r      <= 1'b0;
                        div_clear_r <= 1'b0;
                        div_en_r    <= 1'b1;
                        busy_r      <= 1'b1;
                        bit_cnt     <= '0;
                        state       <= SETUP;
                    end
                end

                // One full divided period with CS low and SCLK parked low:
                // the first divider rise is swallowed, the first fall starts shifting.
                SETUP: begin
                    sclk_r <= 1'b0;
                    if (sclk_fall) begin
                        state <= SHIFT;
                    end
                end

                SHIFT: begin
                    sclk_r <= bus.sclk_div_i;
                    if (sclk_rise) begin
                        shift_reg <= shift_next;
                        bit_cnt   <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            state <= HOLD;
                        end
                    end
                end

                // Keep CS low through the final high phase so the ADC sees a
                // complete last clock before the frame closes.
                HOLD: begin
                    if (sclk_fall) begin
                        cs_n_r      <= 1'b1;
                        sclk_r      <= 1'b0;
                        data_r      <= shift_reg;
                        valid_r     <= 1'b1;
                        div_en_r    <= 1'b0;
                        div_clear_r <= 1'b1;
                        rec_cnt     <= REC_LOAD;
                        state       <= RECOVER;
                    end else begin
                        sclk_r <= bus.sclk_div_i;
                    end
                end

                RECOVER: begin
                    if (rec_cnt <= REC_ONE) begin
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        rec_cnt <= rec_cnt - 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.cs_n_o      = cs_n_r;
    assign bus.sclk_o      = sclk_r;
    assign bus.div_en_o    = div_en_r;
    assign bus.div_clear_o = div_clear_r;
    assign bus.busy_o      = busy_r;
    assign bus.valid_o     = valid_r;
    assign bus.data_o      = data_r;

endmodule
